adc_stat_engine: RTL

The ADC statistics and PFD-offset calibration engine sits inside the digital core, one instance per ADC bank (`Nti` main lanes or `Nti_rep` replica lanes). It is clocked by the divided averaging clock. It consumes the debug configuration the JTAG side drives: averaging window, histogram bin and dead-zone, and PFD-offset enable/override. It produces the per-lane statistics JTAG reads back: average, sum, center/side histogram counts, and the active PFD offset.

---
 rtl/const_pack.sv | 24 ++
 rtl/adc_stat_engine_if.sv | 43 ++++
 rtl/adc_stat_lane.sv | 131 +++++++++++++
 rtl/adc_stat_engine.sv | 111 +++++++++++
 4 files changed

// File: rtl/const_pack.sv
// const_pack: constants and the FSM state type shared by the ADC statistics
// engine, its per-lane datapath and its interface.
package const_pack;

    localparam int Nadc     = 8;   // signed ADC sample width
    localparam int Nrange   = 5;   // width of window / bin / dead-zone controls
    localparam int Nti      = 4;   // main-bank lane count
    localparam int Nti_rep  = 2;   // replica-bank lane count
    localparam int SUM_W    = 24;  // window sum width
    localparam int NAVG_MAX = 16;  // largest usable window exponent

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        PUBLISH = 2'd2
    } adc_stat_state_t;

    // Window exponents above 16 are treated as 16, so 2^16 samples of a
    // 7-bit magnitude always fit in the 24-bit sum.
    function automatic logic [4:0] clamp_navg(input logic [Nrange-1:0] n);
        return (n > Nrange'(NAVG_MAX)) ? 5'(NAVG_MAX) : 5'(n);
    endfunction

endpackage

// File: rtl/adc_stat_engine_if.sv
// adc_stat_engine_if: debug-configuration inputs and per-lane statistics
// outputs of one ADC statistics engine instance.
interface adc_stat_engine_if
    import const_pack::*;
#(
    parameter int Nlanes = const_pack::Nti,
    parameter int Nadc   = const_pack::Nadc,
    parameter int Nrange = const_pack::Nrange
);

    logic signed [Nadc-1:0]   din                [Nlanes];
    logic                     din_vld;
    logic [Nrange-1:0]        Navg_adc;
    logic [Nrange-1:0]        Nbin_adc;
    logic [Nrange-1:0]        DZ_hist_adc;
    logic                     en_pfd_cal;
    logic                     en_ext_pfd_offset;
    logic signed [Nadc-1:0]   ext_pfd_offset     [Nlanes];

    logic signed [Nadc-1:0]   adcout_avg         [Nlanes];
    logic signed [SUM_W-1:0]  adcout_sum         [Nlanes];
    logic [2**Nrange-1:0]     adcout_hist_center [Nlanes];
    logic [2**Nrange-1:0]     adcout_hist_side   [Nlanes];
    logic signed [Nadc-1:0]   pfd_offset         [Nlanes];
    logic                     stat_upd;

    // Configuration / sample side (JTAG debug block, ADC front end).
    modport master (
        output din, din_vld, Navg_adc, Nbin_adc, DZ_hist_adc,
               en_pfd_cal, en_ext_pfd_offset, ext_pfd_offset,
        input  adcout_avg, adcout_sum, adcout_hist_center, adcout_hist_side,
               pfd_offset, stat_upd
    );

    // Statistics engine side.
    modport slave (
        input  din, din_vld, Navg_adc, Nbin_adc, DZ_hist_adc,
               en_pfd_cal, en_ext_pfd_offset, ext_pfd_offset,
        output adcout_avg, adcout_sum, adcout_hist_center, adcout_hist_side,
               pfd_offset, stat_upd
    );

endinterface

// File: rtl/adc_stat_lane.sv
// adc_stat_lane: one lane of the ADC statistics engine -- window accumulator,
// published sum/average, optional histogram counters and the PFD offset.
// Histogram logic is compiled in only when ADC_STAT_HIST_EN is defined.
module adc_stat_lane
    import const_pack::*;
#(
    parameter int Nadc   = const_pack::Nadc,
    parameter int Nrange = const_pack::Nrange
) (
    input  logic                    clk,
    input  logic                    rstb,
    input  logic                    clr_i,      // restart window (IDLE / PUBLISH)
    input  logic                    acc_en_i,   // valid sample inside a window
    input  logic                    pub_i,      // publish cycle
    input  logic [4:0]              navg_i,     // clamped window exponent
    input  logic [Nrange-1:0]       dz_i,
    input  logic [Nrange-1:0]       nbin_i,
    input  logic signed [Nadc-1:0]  din_i,
    input  logic                    cal_en_i,
    input  logic                    ext_en_i,
    input  logic signed [Nadc-1:0]  ext_off_i,
    output logic signed [Nadc-1:0]  avg_o,
    output logic signed [SUM_W-1:0] sum_o,
    output logic [2**Nrange-1:0]    hist_c_o,
    output logic [2**Nrange-1:0]    hist_s_o,
    output logic signed [Nadc-1:0]  pfd_o
);

    localparam int HW = 2**Nrange;

    logic signed [SUM_W-1:0] acc_q, acc_d;
    logic signed [SUM_W-1:0] acc_shr;
    logic signed [Nadc-1:0]  avg_new;
    logic signed [SUM_W-1:0] sum_q;
    logic signed [Nadc-1:0]  avg_q;
    logic signed [Nadc-1:0]  pfd_q;

    // Arithmetic shift floors toward minus infinity; result truncated to Nadc.
    assign acc_shr = acc_q >>> navg_i;
    assign avg_new = acc_shr[Nadc-1:0];

    // Next accumulator value: cleared between windows, sign-extended add on valid.
    always_comb begin
        // NOTE: assign a default before any branch so no path leaves acc_d unassigned (no latch).
        acc_d = acc_q;
        if (clr_i)
            acc_d = '0;
        else if (acc_en_i)
            acc_d = acc_q + SUM_W'(din_i);
    end

    // Accumulator register and the published sum/average.
    always_ff @(posedge clk or negedge rstb) begin
        // NOTE: sequential state uses non-blocking assignments so all registers sample the same edge.
        if (!rstb) begin
            acc_q <= '0;
            sum_q <= '0;
            avg_q <= '0;
        end else begin
            acc_q <= acc_d;
            if (pub_i) begin
                sum_q <= acc_q;
                avg_q <= avg_new;
            end
        end
    end

    // Active PFD offset: external override every cycle, else calibrate at publish.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb)
            pfd_q <= '0;
        else if (ext_en_i)
            pfd_q <= ext_off_i;
        else if (pub_i && cal_en_i)
            pfd_q <= avg_new;
    end

`ifdef ADC_STAT_HIST_EN
    localparam int CW = ((Nadc > Nrange) ? Nadc : Nrange) + 1;

    logic signed [Nadc:0] diff;
    logic [Nadc:0]        dist;
    logic [CW-1:0]        dist_x, dz_x, hi_x;
    logic                 in_center, in_side;
    logic [HW-1:0]        hc_q, hs_q, hc_pub_q, hs_pub_q;

    // Distance from the previously published average, one bit wider than a sample.
    assign diff      = (Nadc+1)'(din_i) - (Nadc+1)'(avg_q);
    assign dist      = diff[Nadc] ? $unsigned(-diff) : $unsigned(diff);
    assign dist_x    = CW'(dist);
    assign dz_x      = CW'(dz_i);
    assign hi_x      = CW'(dz_i) + CW'(nbin_i);
    assign in_center = (dist_x < dz_x);
    assign in_side   = !in_center && (dist_x < hi_x);

    // Saturating center/side counters, published alongside the sum.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            hc_q     <= '0;
            hs_q     <= '0;
            hc_pub_q <= '0;
            hs_pub_q <= '0;
        end else begin
            if (clr_i) begin
                hc_q <= '0;
                hs_q <= '0;
            end else if (acc_en_i) begin
                if (in_center && (hc_q != '1)) hc_q <= hc_q + HW'(1);
                if (in_side   && (hs_q != '1)) hs_q <= hs_q + HW'(1);
            end
            if (pub_i) begin
                hc_pub_q <= hc_q;
                hs_pub_q <= hs_q;
            end
        end
    end

    assign hist_c_o = hc_pub_q;
    assign hist_s_o = hs_pub_q;
`else
    logic unused_hist_cfg;
    assign unused_hist_cfg = ^{dz_i, nbin_i};
    assign hist_c_o = '0;
    assign hist_s_o = '0;
`endif

    assign avg_o = avg_q;
    assign sum_o = sum_q;
    assign pfd_o = pfd_q;

endmodule

// File: rtl/adc_stat_engine.sv
// adc_stat_engine: ADC statistics and PFD-offset calibration for one ADC bank.
// Shared window FSM, sample counter and config shadows; one adc_stat_lane per
// lane. Define ADC_STAT_HIST_EN to compile in the histogram datapath.
module adc_stat_engine
    import const_pack::*;
#(
    parameter int Nlanes = const_pack::Nti,
    parameter int Nadc   = const_pack::Nadc,
    parameter int Nrange = const_pack::Nrange
) (
    input  logic             clk,
    input  logic             rstb,
    adc_stat_engine_if.slave bus
);

    adc_stat_state_t   state_q;
    logic [4:0]        navg_q;
    logic [15:0]       cnt_q;
    logic              stat_upd_q;
    logic [15:0]       win_last;
    logic              acc_en, clr, pub;
    logic [Nrange-1:0] dz_lane, nbin_lane;

    assign win_last = 16'((17'd1 << navg_q) - 17'd1);
    assign acc_en   = (state_q == ACCUM) && bus.din_vld;
    assign clr      = (state_q != ACCUM);
    assign pub      = (state_q == PUBLISH);

`ifdef ADC_STAT_HIST_EN
    logic [Nrange-1:0] nbin_q, dz_q;

    // Histogram shadows, latched on every entry into ACCUM.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            nbin_q <= '0;
            dz_q   <= '0;
        end else if (state_q != ACCUM) begin
            nbin_q <= bus.Nbin_adc;
            dz_q   <= bus.DZ_hist_adc;
        end
    end

    assign dz_lane   = dz_q;
    assign nbin_lane = nbin_q;
`else
    logic unused_hist_in;
    assign unused_hist_in = ^{bus.Nbin_adc, bus.DZ_hist_adc};
    assign dz_lane   = '0;
    assign nbin_lane = '0;
`endif

    // Window sequencer IDLE -> ACCUM -> PUBLISH -> ACCUM with registered stat_upd.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q    <= IDLE;
            navg_q     <= '0;
            cnt_q      <= '0;
            stat_upd_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE, PUBLISH: begin
                    state_q    <= ACCUM;
                    navg_q     <= clamp_navg(bus.Navg_adc);
                    cnt_q      <= '0;
                    stat_upd_q <= (state_q == PUBLISH);
                end
                ACCUM: begin
                    stat_upd_q <= 1'b0;
                    if (bus.din_vld) begin
                        if (cnt_q == win_last)
                            state_q <= PUBLISH;
                        else
                            cnt_q <= cnt_q + 16'd1;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    stat_upd_q <= 1'b0;
                end
            endcase
        end
    end

    for (genvar g = 0; g < Nlanes; g++) begin : g_lane
        adc_stat_lane #(
            .Nadc   (Nadc),
            .Nrange (Nrange)
        ) u_lane (
            .clk       (clk),
            .rstb      (rstb),
            .clr_i     (clr),
            .acc_en_i  (acc_en),
            .pub_i     (pub),
            .navg_i    (navg_q),
            .dz_i      (dz_lane),
            .nbin_i    (nbin_lane),
            .din_i     (bus.din[g]),
            .cal_en_i  (bus.en_pfd_cal),
            .ext_en_i  (bus.en_ext_pfd_offset),
            .ext_off_i (bus.ext_pfd_offset[g]),
            .avg_o     (bus.adcout_avg[g]),
            .sum_o     (bus.adcout_sum[g]),
            .hist_c_o  (bus.adcout_hist_center[g]),
            .hist_s_o  (bus.adcout_hist_side[g]),
            .pfd_o     (bus.pfd_offset[g])
        );
    end

    assign bus.stat_upd = stat_upd_q;

endmodule
